reg_bank_wb: RTL

REG_BANK_WB -- requirements
Module: reg_bank_wb

---
 rtl/reg_bank_wb.sv | 127 ++++++++++++
 1 files changed

// File: rtl/reg_bank_wb.sv
// Register bank with a one-entry write-back stage, a sequenced clear and a synchronous preset.
// Optional read-after-write forwarding from the write-back stage: define REG_BANK_WB_BYPASS_EN.
module reg_bank_wb #(
    parameter int unsigned NrOfBits    = 8,
    parameter int unsigned NrOfRegs    = 4,
    parameter int unsigned AddrBits    = 2,
    parameter int unsigned ActiveLevel = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic                we,
    input  logic [AddrBits-1:0] waddr,
    input  logic [NrOfBits-1:0] D,
    input  logic [AddrBits-1:0] raddr,
    input  logic                cs,
    input  logic                pre,
    input  logic                clr_start,
    output logic [NrOfBits-1:0] Q,
    output logic                busy,
    output logic [NrOfRegs-1:0] dirty
);

    localparam int unsigned IdxW = (NrOfRegs > 1) ? $clog2(NrOfRegs) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    logic                active_clk;
    logic                advance;
    logic                waddr_ok;
    logic                raddr_ok;
    logic [NrOfBits-1:0] regs [NrOfRegs];
    logic                wb_valid;
    logic [AddrBits-1:0] wb_addr;
    logic [NrOfBits-1:0] wb_data;
    clr_state_t          state;
    logic [IdxW-1:0]     clr_idx;
    logic [NrOfBits-1:0] rd_data;

    // ActiveLevel selects which Clock edge updates state
    assign active_clk = (ActiveLevel != 0) ? Clock : ~Clock;
    assign advance    = ClockEnable & Tick;
    assign waddr_ok   = (32'(waddr) < NrOfRegs);
    assign raddr_ok   = (32'(raddr) < NrOfRegs);

    // Priority inside an advance: preset, then clear sequencing, then the write path
    always_ff @(posedge active_clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            clr_idx  <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            dirty    <= '0;
            for (int i = 0; i < int'(NrOfRegs); i++) begin
                regs[i] <= '0;
            end
        end else if (advance) begin
            if (pre) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                clr_idx  <= '0;
                wb_valid <= 1'b0;
                dirty    <= '1;
                for (int i = 0; i < int'(NrOfRegs); i++) begin
                    regs[i] <= '1;
                end
            end else begin
                case (state)
                    ST_CLEAR: begin
                        regs[clr_idx]  <= '0;
                        dirty[clr_idx] <= 1'b0;
                        if (clr_idx == IdxW'(NrOfRegs - 1)) begin
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            clr_idx <= '0;
                        end else begin
                            clr_idx <= clr_idx + IdxW'(1);
                        end
                    end
                    default: begin
                        if (clr_start) begin
                            // Entering the clear drops any uncommitted write
                            state    <= ST_CLEAR;
                            busy     <= 1'b1;
                            clr_idx  <= '0;
                            wb_valid <= 1'b0;
                        end else begin
                            if (wb_valid) begin
                                regs[IdxW'(wb_addr)]  <= wb_data;
                                dirty[IdxW'(wb_addr)] <= 1'b1;
                            end
                            if (we && waddr_ok) begin
                                wb_valid <= 1'b1;
                                wb_addr  <= waddr;
                                wb_data  <= D;
                            end else begin
                                wb_valid <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Read path: out-of-range addresses read zero
    always_comb begin
        rd_data = '0;
        if (raddr_ok) begin
            rd_data = regs[IdxW'(raddr)];
        end
`ifdef REG_BANK_WB_BYPASS_EN
        if (wb_valid && (raddr == wb_addr)) begin
            rd_data = wb_data;
        end
`endif
    end

    assign Q = cs ? {NrOfBits{1'bz}} : rd_data;

endmodule
